// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the banked RAM with hardware clear.
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned ADDR_W_DEF    = 9;
   localparam int unsigned BANK_BITS_DEF = 3;

   // Words per bank for a given total address width and bank count.
   function automatic int unsigned bank_depth(input int unsigned addr_w,
                                              input int unsigned bank_bits);
      return 32'(1) << (addr_w - bank_bits);
   endfunction

endpackage

// File: rtl/ram_bank.sv
// One storage bank: synchronous write, combinational read.
module ram_bank #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OFF_W  = 6
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [OFF_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [OFF_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 32'(1) << OFF_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_banked_clr.sv
// Parametrised banked RAM with valid/ready requests, registered read and
// a clear engine that zeroes every bank after reset or on request.
module ram_banked_clr
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned BANK_BITS = BANK_BITS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              clr,
   output logic              busy
);

   localparam int unsigned OFF_W  = ADDR_W - BANK_BITS;
   localparam int unsigned N_BANK = 32'(1) << BANK_BITS;
   localparam int unsigned DEPTH  = bank_depth(ADDR_W, BANK_BITS);
   localparam logic [OFF_W-1:0] LAST_PTR = OFF_W'(DEPTH - 1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [OFF_W-1:0]    r_clr_ptr;
   logic [OFF_W-1:0]    w_clr_ptr_nxt;
   logic                r_busy;
   logic                r_req_ready;
   logic                r_rd_valid;
   logic [DATA_W-1:0]   r_rd_data;

   logic                w_accept;
   logic                w_wr_accept;
   logic                w_rd_accept;
   logic [BANK_BITS-1:0] w_bank_sel;
   logic [OFF_W-1:0]    w_off;
   logic [N_BANK-1:0]   w_bank_we;
   logic [OFF_W-1:0]    w_bank_waddr;
   logic [DATA_W-1:0]   w_bank_wdata;
   logic [DATA_W-1:0]   w_bank_rdata [N_BANK];

   assign w_bank_sel  = req_addr[ADDR_W-1 -: BANK_BITS];
   assign w_off       = req_addr[OFF_W-1:0];
   assign w_accept    = req_valid & r_req_ready;
   assign w_wr_accept = w_accept & req_we;
   assign w_rd_accept = w_accept & ~req_we;

   // Next state, clear pointer and bank write steering.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_bank_we     = '0;
      w_bank_waddr  = w_off;
      w_bank_wdata  = req_wdata;
      case (r_state)
         CLEAR: begin
            w_bank_we    = '1;
            w_bank_waddr = r_clr_ptr;
            w_bank_wdata = '0;
            // Terminal compare precedes the increment, so the pointer never wraps.
            if (r_clr_ptr == LAST_PTR) begin
               w_state_nxt   = RUN;
               w_clr_ptr_nxt = '0;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + OFF_W'(1);
            end
         end
         RUN: begin
            if (w_wr_accept) begin
               w_bank_we[w_bank_sel] = 1'b1;
            end
            if (clr) begin
               w_state_nxt = CLEAR;
            end
         end
         default: begin
            w_state_nxt   = CLEAR;
            w_clr_ptr_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= CLEAR;
         r_clr_ptr   <= '0;
         r_busy      <= 1'b1;
         r_req_ready <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_ptr   <= w_clr_ptr_nxt;
         r_busy      <= (w_state_nxt == CLEAR);
         r_req_ready <= (w_state_nxt == RUN);
         r_rd_valid  <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_data <= w_bank_rdata[w_bank_sel];
         end
      end
   end

   for (genvar b = 0; b < N_BANK; b++) begin : g_bank
      ram_bank #(
         .DATA_W (DATA_W),
         .OFF_W  (OFF_W)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_bank_we[b]),
         .i_waddr (w_bank_waddr),
         .i_wdata (w_bank_wdata),
         .i_raddr (w_off),
         .o_rdata (w_bank_rdata[b])
      );
   end

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_ram_banked_clr.sv
// Scoreboard bench for ram_banked_clr: default build (dut0) and a
// DATA_W=8/ADDR_W=6/BANK_BITS=1 build (dut1) against an array model.
module tb_ram_banked_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst       = 2'b00;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_we    = 2'b00;
   logic [1:0]  clr       = 2'b00;
   logic [1:0]  req_ready;
   logic [1:0]  rd_valid;
   logic [1:0]  busy;
   logic [8:0]  req_addr  [2];
   logic [15:0] req_wdata [2];
   logic [15:0] rd_data0;
   logic [7:0]  rd_data1;
   logic [5:0]  addr1;
   logic [7:0]  wdata1;

   assign addr1  = req_addr[1][5:0];
   assign wdata1 = req_wdata[1][7:0];

   ram_banked_clr u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rd_valid(rd_valid[0]), .rd_data(rd_data0), .clr(clr[0]), .busy(busy[0])
   );

   ram_banked_clr #(.DATA_W(8), .ADDR_W(6), .BANK_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(addr1), .req_wdata(wdata1),
      .rd_valid(rd_valid[1]), .rd_data(rd_data1), .clr(clr[1]), .busy(busy[1])
   );

   logic [15:0] model [2][512];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   int checks = 0;
   int errors = 0;
   int run [2];
   int max_run [2];

   function automatic int depth(input int d);
      return (d == 0) ? 512 : 64;
   endfunction

   function automatic logic [15:0] dmask(input int d);
      return (d == 0) ? 16'hFFFF : 16'h00FF;
   endfunction

   function automatic logic [15:0] rdd(input int d);
      return (d == 0) ? rd_data0 : {8'h00, rd_data1};
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [15:0] v);
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic flush(input int d);
      if (d == 0) q0.delete();
      else        q1.delete();
   endtask

   task automatic zero_model(input int d);
      for (int i = 0; i < 512; i++) model[d][i] = 16'h0000;
   endtask

   // Drive one request at a negedge and hold it until req_ready is seen.
   task automatic req(input int d, input bit we, input int addr, input int data,
                      input bit with_clr);
      int n;
      int a;
      a = addr % depth(d);
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = 9'(a);
      req_wdata[d] = 16'(data) & dmask(d);
      clr[d]       = with_clr;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (req_ready[d] !== 1'b1) begin
         chk("req_timeout", d, 32'(req_ready[d]), 32'd1);
      end else begin
         if (we) model[d][a] = 16'(data) & dmask(d);
         else    push(d, model[d][a]);
         if (with_clr) zero_model(d);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      req_valid[d] = 1'b0;
      clr[d]       = 1'b0;
   endtask

   // Count busy cycles from the current negedge; ready must stay low throughout.
   task automatic wait_clear(input int d, input int exp);
      int cnt;
      int bad;
      cnt = 0;
      bad = 0;
      while (busy[d] === 1'b1 && cnt < 200) begin
         if (req_ready[d] !== 1'b0) bad++;
         cnt++;
         @(negedge clk);
      end
      req_valid[d] = 1'b0;
      chk("clear_cycles", d, 32'(cnt), 32'(exp));
      chk("ready_low_in_clear", d, 32'(bad), 32'd0);
      chk("ready_after_clear", d, 32'(req_ready[d]), 32'd1);
   endtask

   task automatic do_reset(input int d, input int exp);
      idle(d);
      repeat (2) @(negedge clk);
      rst[d] = 1'b1;
      flush(d);
      zero_model(d);
      @(negedge clk);
      chk("rst_busy", d, 32'(busy[d]), 32'd1);
      chk("rst_ready", d, 32'(req_ready[d]), 32'd0);
      chk("rst_rd_valid", d, 32'(rd_valid[d]), 32'd0);
      chk("rst_rd_data", d, 32'(rdd(d)), 32'd0);
      rst[d] = 1'b0;
      wait_clear(d, exp);
   endtask

   task automatic start_clr(input int d);
      @(negedge clk);
      clr[d] = 1'b1;
      zero_model(d);
      @(negedge clk);
      clr[d] = 1'b0;
   endtask

   task automatic random_ops(input int d, input int n);
      int r;
      int a;
      int v;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         a = $urandom_range(0, depth(d) - 1);
         v = $urandom_range(0, 65535);
         if (r < 4) begin
            req(d, 1'b1, a, v, 1'b0);
         end else if (r < 8) begin
            req(d, 1'b0, a, 0, 1'b0);
         end else if (r == 8) begin
            idle(d);
         end else begin
            req(d, 1'b1, a, v, 1'b0);
            req(d, 1'b0, a, 0, 1'b0);
         end
      end
      idle(d);
   endtask

   // Monitor: every rd_valid cycle pops one expected word.
   always @(negedge clk) begin
      logic [15:0] e;
      for (int d = 0; d < 2; d++) begin
         if (rd_valid[d] === 1'b1) begin
            run[d]++;
            if (run[d] > max_run[d]) max_run[d] = run[d];
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rd_valid dut%0d: got rd_valid=1 expected 0", d);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk("rd_data", d, 32'(rdd(d)), 32'(e));
            end
         end else begin
            run[d] = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      req_addr[0] = '0; req_addr[1] = '0;
      req_wdata[0] = '0; req_wdata[1] = '0;
      run[0] = 0; run[1] = 0; max_run[0] = 0; max_run[1] = 0;
      zero_model(0);
      zero_model(1);

      // ---- default build ----
      do_reset(0, 64);
      req(0, 1'b0, 0, 0, 1'b0);
      req(0, 1'b0, 63, 0, 1'b0);
      req(0, 1'b0, 64, 0, 1'b0);
      req(0, 1'b0, 511, 0, 1'b0);
      req(0, 1'b1, 'h1A3, 'hBEEF, 1'b0);
      req(0, 1'b0, 'h1A3, 0, 1'b0);
      req(0, 1'b0, 'h0A3, 0, 1'b0);
      idle(0);

      // Streaming: 512 writes then 512 back-to-back reads.
      repeat (2) @(negedge clk);
      max_run[0] = 0;
      for (int i = 0; i < 512; i++) req(0, 1'b1, i, i * 3, 1'b0);
      for (int i = 0; i < 512; i++) req(0, 1'b0, i, 0, 1'b0);
      idle(0);
      repeat (2) @(negedge clk);
      chk("stream_rd_valid_run", 0, 32'(max_run[0]), 32'd512);

      // clr together with a write: write commits, then everything is zeroed.
      req(0, 1'b1, 5, 'h1234, 1'b1);
      @(negedge clk);
      clr[0] = 1'b0;
      req_valid[0] = 1'b0;
      wait_clear(0, 64);
      for (int i = 0; i < 512; i++) req(0, 1'b0, i, 0, 1'b0);
      idle(0);

      // clr together with a read: pre-clear data returned; held request ignored.
      req(0, 1'b1, 7, 'h5555, 1'b0);
      req(0, 1'b0, 7, 0, 1'b1);
      @(negedge clk);
      chk("rd_valid_first_clear", 0, 32'(rd_valid[0]), 32'd1);
      clr[0] = 1'b0;
      req_valid[0] = 1'b1;
      req_we[0] = 1'b1;
      req_addr[0] = 9'd9;
      req_wdata[0] = 16'hAAAA;
      wait_clear(0, 64);
      req(0, 1'b0, 9, 0, 1'b0);
      req(0, 1'b0, 7, 0, 1'b0);
      idle(0);

      random_ops(0, 300);

      // Reset during a read strobe.
      req(0, 1'b1, 3, 'h0077, 1'b0);
      req(0, 1'b0, 3, 0, 1'b0);
      @(posedge clk);
      #1;
      chk("rd_valid_before_rst", 0, 32'(rd_valid[0]), 32'd1);
      rst[0] = 1'b1;
      flush(0);
      zero_model(0);
      #1;
      chk("rd_valid_dropped", 0, 32'(rd_valid[0]), 32'd0);
      chk("rst_rd_data_mid", 0, 32'(rd_data0), 32'd0);
      chk("rst_busy_mid", 0, 32'(busy[0]), 32'd1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst[0] = 1'b0;
      wait_clear(0, 64);

      // Reset at clear cycle 30: clear must rerun the full length.
      req(0, 1'b1, 20, 'h1111, 1'b0);
      idle(0);
      start_clr(0);
      repeat (29) @(negedge clk);
      rst[0] = 1'b1;
      #1;
      chk("rst_busy_clear", 0, 32'(busy[0]), 32'd1);
      chk("rst_ready_clear", 0, 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      wait_clear(0, 64);
      req(0, 1'b0, 20, 0, 1'b0);
      req(0, 1'b0, 3, 0, 1'b0);
      idle(0);

      // ---- DATA_W=8, ADDR_W=6, BANK_BITS=1 build ----
      do_reset(1, 32);
      req(1, 1'b1, 'h23, 'hEF, 1'b0);
      req(1, 1'b0, 'h23, 0, 1'b0);
      req(1, 1'b0, 'h03, 0, 1'b0);
      req(1, 1'b1, 5, 'h34, 1'b1);
      @(negedge clk);
      clr[1] = 1'b0;
      req_valid[1] = 1'b0;
      wait_clear(1, 32);
      for (int i = 0; i < 64; i++) req(1, 1'b0, i, 0, 1'b0);
      idle(1);
      random_ops(1, 150);

      repeat (4) @(negedge clk);
      chk("queue_empty", 0, 32'(q0.size()), 32'd0);
      chk("queue_empty", 1, 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
